// File: rtl/quotient_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quotient_converter_pkg
//  Description : Shared types and constants for the SRT quotient converter:
//                FSM state encoding, remainder-correction codes and opCode
//                bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package quotient_converter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] REMCORR_NONE = 2'b00;
    localparam logic [1:0] REMCORR_ADD  = 2'b01;
    localparam logic [1:0] REMCORR_SUB  = 2'b10;

    localparam int OP_DIV      = 2;
    localparam int OP_UNSIGNED = 0;

endpackage : quotient_converter_pkg
`default_nettype wire

// File: rtl/otf_digit_update.sv
`default_nettype none
// ============================================================================
//  Module      : otf_digit_update
//  Description : Combinational on-the-fly conversion step. Given the current
//                Q/QM pair and one radix-2 SRT digit {Non0,SignSel}, produces
//                the next Q/QM pair.
//  Ports       : q_i, qm_i        low W-1 bits of current Q / QM (the MSB is
//                                 shifted out and therefore not needed)
//                non0_i, signsel_i kernel digit bits
//                sd_i             latched divisor sign
//                q_next_o, qm_next_o  next Q / QM, W bits
//  Revision    : 1.0  initial release
// ============================================================================
module otf_digit_update #(
    parameter int W = 33
) (
    input  logic [W-2:0] q_i,
    input  logic [W-2:0] qm_i,
    input  logic         non0_i,
    input  logic         signsel_i,
    input  logic         sd_i,
    output logic [W-1:0] q_next_o,
    output logic [W-1:0] qm_next_o
);

    // Digit is negative when the kernel's sign select disagrees with the
    // divisor sign; zero when Non0 is clear.
    logic w_neg;
    assign w_neg = signsel_i ^ sd_i;

    always_comb begin
        q_next_o  = {q_i, 1'b0};
        qm_next_o = {qm_i, 1'b1};
        if (non0_i) begin
            if (w_neg) begin
                q_next_o  = {qm_i, 1'b1};
                qm_next_o = {qm_i, 1'b0};
            end else begin
                q_next_o  = {q_i, 1'b1};
                qm_next_o = {q_i, 1'b0};
            end
        end
    end

endmodule : otf_digit_update
`default_nettype wire

// File: rtl/quotient_converter.sv
`default_nettype none
// ============================================================================
//  Module      : quotient_converter
//  Description : Receives one radix-2 SRT quotient digit per cycle from the
//                divider kernel, builds the binary quotient with on-the-fly
//                conversion (Q/QM), then applies the final sign correction
//                from the remainder sign and reports the remainder fix-up.
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                start, opCode, *Sign      division request and operand signs
//                digit_valid, SignSel, Non0  quotient digit stream
//                rem_valid, remSign, remZero final remainder flags
//                busy, quot_valid          status / one-cycle result strobe
//                quotient, remCorr         corrected quotient, remainder fix-up
//  Revision    : 1.0  initial release
// ============================================================================
module quotient_converter
    import quotient_converter_pkg::*;
#(
    parameter int PARALLELISM = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             opCode,
    input  logic                   dividendSign,
    input  logic                   divisorSign,
    input  logic                   digit_valid,
    input  logic                   SignSel,
    input  logic                   Non0,
    input  logic                   rem_valid,
    input  logic                   remSign,
    input  logic                   remZero,
    output logic                   busy,
    output logic                   quot_valid,
    output logic [PARALLELISM-1:0] quotient,
    output logic [1:0]             remCorr
);

    localparam int c_qw = PARALLELISM + 1;
    localparam int c_cw = $clog2(PARALLELISM + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(PARALLELISM - 1);

    state_e                   state_q,    state_d;
    logic [c_qw-1:0]          q_q,        q_d;
    logic [c_qw-1:0]          qm_q,       qm_d;
    logic [c_cw-1:0]          count_q,    count_d;
    logic                     sd_q,       sd_d;
    logic                     sx_q,       sx_d;
    logic [PARALLELISM-1:0]   quotient_q, quotient_d;
    logic [1:0]               remcorr_q,  remcorr_d;

    logic [c_qw-1:0] w_q_next;
    logic [c_qw-1:0] w_qm_next;
    logic [c_qw-1:0] w_q_inc;
    logic            w_wrong;
    logic            w_unused;

    otf_digit_update #(
        .W (c_qw)
    ) u_otf (
        .q_i       (q_q[c_qw-2:0]),
        .qm_i      (qm_q[c_qw-2:0]),
        .non0_i    (Non0),
        .signsel_i (SignSel),
        .sd_i      (sd_q),
        .q_next_o  (w_q_next),
        .qm_next_o (w_qm_next)
    );

    // Q+1 wraps modulo 2^(PARALLELISM+1); only the low bits reach the output.
    assign w_q_inc = q_q + c_qw'(1);

    // The remainder has the wrong sign when it is non-zero and disagrees
    // with the dividend sign.
    assign w_wrong = !remZero && (remSign != sx_q);

    // MSBs of the guard-extended Q/QM and opCode[1] never reach an output.
    assign w_unused = ^{q_q[c_qw-1], qm_q[c_qw-1], w_q_inc[c_qw-1], opCode[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            qm_q       <= '1;
            count_q    <= '0;
            sd_q       <= 1'b0;
            sx_q       <= 1'b0;
            quotient_q <= '0;
            remcorr_q  <= REMCORR_NONE;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            qm_q       <= qm_d;
            count_q    <= count_d;
            sd_q       <= sd_d;
            sx_q       <= sx_d;
            quotient_q <= quotient_d;
            remcorr_q  <= remcorr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        qm_d       = qm_q;
        count_d    = count_q;
        sd_d       = sd_q;
        sx_d       = sx_q;
        quotient_d = quotient_q;
        remcorr_d  = remcorr_q;

        case (state_q)
            IDLE: begin
                if (start && opCode[OP_DIV]) begin
                    state_d = ITER;
                    q_d     = '0;
                    qm_d    = '1;
                    count_d = '0;
                    sd_d    = opCode[OP_UNSIGNED] ? 1'b0 : divisorSign;
                    sx_d    = opCode[OP_UNSIGNED] ? 1'b0 : dividendSign;
                end
            end
            ITER: begin
                if (digit_valid) begin
                    q_d     = w_q_next;
                    qm_d    = w_qm_next;
                    count_d = count_q + c_cw'(1);
                    if (count_q == c_last) begin
                        state_d = CORRECT;
                    end
                end
            end
            CORRECT: begin
                if (rem_valid) begin
                    state_d = DONE;
                    if (!w_wrong) begin
                        quotient_d = q_q[PARALLELISM-1:0];
                        remcorr_d  = REMCORR_NONE;
                    end else if (remSign != sd_q) begin
                        quotient_d = qm_q[PARALLELISM-1:0];
                        remcorr_d  = REMCORR_ADD;
                    end else begin
                        quotient_d = w_q_inc[PARALLELISM-1:0];
                        remcorr_d  = REMCORR_SUB;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == ITER) || (state_q == CORRECT);
    assign quot_valid = (state_q == DONE);
    assign quotient   = quotient_q;
    assign remCorr    = remcorr_q;

endmodule : quotient_converter
`default_nettype wire
